// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like bus between the EX stage (master) and the data memory
// responder (slave): request/accept handshake plus an in-order response pulse.
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-addressed data memory behind the SRAM-like bus.
// Accepted requests are queued in order and each is answered with a one-cycle
// data_ok exactly LAT cycles after its accept edge.
// Optional feature macro: DSRAM_RAND_STALL_EN -- an 8-bit LFSR drops addr_ok
// pseudo-randomly (~25% of cycles) to exercise the requester's wait path.

// One response-queue slot: load flag, captured load data and an ageing counter.
module dsr_entry #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic        live,
  input  logic        load_in,
  input  logic [31:0] data_in,
  output logic        is_load,
  output logic [31:0] data,
  output logic [3:0]  cnt
);
  logic        is_load_q, is_load_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;

  // Load a fresh slot on accept, otherwise age a live slot toward zero.
  always_comb begin
    is_load_d = is_load_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    if (wen) begin
      is_load_d = load_in;
      data_d    = data_in;
      cnt_d     = 4'(LAT - 1);
    end else if (live && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_load_q <= 1'b0;
      data_q    <= 32'h0;
      cnt_q     <= 4'd0;
    end else begin
      is_load_q <= is_load_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign is_load = is_load_q;
  assign data    = data_q;
  assign cnt     = cnt_q;
endmodule

module data_sram_responder #(
  parameter int MEM_AW     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LAT        = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_sram_responder_if.slave   bus
);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;
  localparam int MEM_WORDS = 1 << MEM_AW;

  logic              stall;
  logic              acc;
  logic              pop;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       ld_word;
  logic [31:0]       mem [MEM_WORDS];

  logic [FIFO_DEPTH-1:0]       e_live;
  logic [FIFO_DEPTH-1:0]       e_wen;
  logic [FIFO_DEPTH-1:0]       e_is_load;
  logic [FIFO_DEPTH-1:0][31:0] e_data;
  logic [FIFO_DEPTH-1:0][3:0]  e_cnt;

  logic        head_is_load;
  logic [31:0] head_data;
  logic [3:0]  head_cnt;

  // size is informational and address bits outside the word index alias away.
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

`ifdef DSRAM_RAND_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, one step per cycle.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 8'h5A;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Word index; loads read the array as it stands before this edge, so any
  // store accepted earlier is already visible and a same-edge store is not.
  assign idx     = bus.addr[MEM_AW+1:2];
  assign ld_word = mem[idx];

  // No pass-through when full: only occupancy before the edge decides accept.
  assign bus.addr_ok = resetn && (count_q < CW'(FIFO_DEPTH)) && !stall;
  assign acc         = bus.req && bus.addr_ok;

  // Per-slot liveness is distance from the head; the write slot is wr_ptr.
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off       = PW'(i) - rd_ptr_q;
    assign e_live[i] = ({1'b0, off} < count_q);
    assign e_wen[i]  = acc && (wr_ptr_q == PW'(i));

    dsr_entry #(.LAT(LAT)) u_ent (
      .clk     (clk),
      .resetn  (resetn),
      .wen     (e_wen[i]),
      .live    (e_live[i]),
      .load_in (~bus.wr),
      .data_in (bus.wr ? 32'h0 : ld_word),
      .is_load (e_is_load[i]),
      .data    (e_data[i]),
      .cnt     (e_cnt[i])
    );
  end

  assign head_is_load = e_is_load[rd_ptr_q];
  assign head_data    = e_data[rd_ptr_q];
  assign head_cnt     = e_cnt[rd_ptr_q];

  // Head answers once its age counter has run out; it pops on the same edge.
  assign bus.data_ok = (count_q != '0) && (head_cnt == 4'd0);
  assign bus.rdata   = head_is_load ? head_data : 32'h0;
  assign pop         = bus.data_ok;

  // Queue bookkeeping: pointers wrap naturally, accept+pop keeps the count.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Backing store: byte-lane writes on accepted stores, contents survive reset.
  always_ff @(posedge clk) begin
    if (acc && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
endmodule
